// File: rtl/bram_port_arbiter_if.sv
// Request/response bundle between one client engine and bram_port_arbiter.
// The client side uses the master modport, the arbiter uses the slave modport.
interface bram_port_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic                  rvalid;
  logic [WIDTH-1:0]      rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter in front of a single-port, read-first, 1-cycle-latency RAM.
// Round-robin by default; define BRAM_ARB_FIXED_PRIO_EN for fixed priority (s0 wins).
module bram_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bram_port_arbiter_if.slave    s0,
  bram_port_arbiter_if.slave    s1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_din,
  input  logic [WIDTH-1:0]      mem_dout
);

  logic grant0;
  logic grant1;
  logic rd_pend;
  logic rd_owner;
  logic rd_hs0;
  logic rd_hs1;

  // Grants are masked while in reset so every output reads 0 during reset.
`ifdef BRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = rst_n & s0.valid;
    grant1 = rst_n & s1.valid & ~s0.valid;
  end
`else
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (s0.valid && s1.valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = s0.valid;
        grant1 = s1.valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end
`endif

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant0) begin
      mem_we   = s0.we;
      mem_addr = s0.addr;
      mem_din  = s0.wdata;
    end else if (grant1) begin
      mem_we   = s1.we;
      mem_addr = s1.addr;
      mem_din  = s1.wdata;
    end
  end

  assign rd_hs0 = grant0 & ~s0.we;
  assign rd_hs1 = grant1 & ~s1.we;

  // rd_owner only matters while rd_pend is set, so it is loaded on reads alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= rd_hs0 | rd_hs1;
      if (rd_hs0 || rd_hs1) begin
        rd_owner <= rd_hs1;
      end
    end
  end

  assign s0.ready  = grant0;
  assign s1.ready  = grant1;
  assign s0.rvalid = rd_pend & ~rd_owner;
  assign s1.rvalid = rd_pend & rd_owner;
  assign s0.rdata  = s0.rvalid ? mem_dout : '0;
  assign s1.rdata  = s1.rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: behavioural RAM, shadow-memory reference,
// directed scenarios followed by randomized two-requester traffic.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 11;
  localparam int DEPTH      = 2048;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } resp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_din;
  logic [WIDTH-1:0]      mem_dout;

  bram_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) s0if ();
  bram_port_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) s1if ();

  bram_port_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s0       (s0if),
    .s1       (s1if),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  // Read-first RAM macro with registered dout.
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [WIDTH-1:0] shadow [DEPTH];
  resp_t            expq [$];
  int               lastServed = 1;
  int               checks = 0;
  int               passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Drive one cycle of requests, predict the winner and check grant and RAM drive.
  task automatic applyStimulus(input logic v0, input logic we0, input logic [ADDR_WIDTH-1:0] a0,
                               input logic [WIDTH-1:0] d0, input logic v1, input logic we1,
                               input logic [ADDR_WIDTH-1:0] a1, input logic [WIDTH-1:0] d1,
                               output int win);
    logic                  v  [2];
    logic                  we [2];
    logic [ADDR_WIDTH-1:0] a  [2];
    logic [WIDTH-1:0]      d  [2];
    resp_t                 r;
    @(negedge clk);
    s0if.valid = v0; s0if.we = we0; s0if.addr = a0; s0if.wdata = d0;
    s1if.valid = v1; s1if.we = we1; s1if.addr = a1; s1if.wdata = d1;
    v[0] = v0; we[0] = we0; a[0] = a0; d[0] = d0;
    v[1] = v1; we[1] = we1; a[1] = a1; d[1] = d1;
    #1;
    win = -1;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    if (v0) win = 0;
    else if (v1) win = 1;
`else
    if (v0 && v1) win = 1 - lastServed;
    else if (v0) win = 0;
    else if (v1) win = 1;
`endif
    checkOutput("s0_ready", {31'b0, s0if.ready}, {31'b0, win == 0});
    checkOutput("s1_ready", {31'b0, s1if.ready}, {31'b0, win == 1});
    if (win >= 0) begin
      checkOutput("mem_we", {31'b0, mem_we}, {31'b0, we[win]});
      checkOutput("mem_addr", {21'b0, mem_addr}, {21'b0, a[win]});
      checkOutput("mem_din", mem_din, d[win]);
      lastServed = win;
      if (we[win]) begin
        shadow[a[win]] = d[win];
      end else begin
        r.port = win;
        r.data = shadow[a[win]];
        r.due  = cycle + 1;
        expq.push_back(r);
      end
    end else begin
      checkOutput("mem_idle", {mem_we, 20'b0, mem_addr} | 32'(mem_din != 0), 32'h0);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expq.delete();
    lastServed = 1;
    for (int k = 0; k < 3; k++) begin
      s0if.valid = 1'($urandom); s0if.we = 1'($urandom);
      s0if.addr = ADDR_WIDTH'($urandom); s0if.wdata = $urandom;
      s1if.valid = 1'($urandom); s1if.we = 1'($urandom);
      s1if.addr = ADDR_WIDTH'($urandom); s1if.wdata = $urandom;
      #1;
      checkOutput("rst_s0_ready", {31'b0, s0if.ready}, 32'h0);
      checkOutput("rst_s1_ready", {31'b0, s1if.ready}, 32'h0);
      checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
      checkOutput("rst_mem_addr", {21'b0, mem_addr}, 32'h0);
      checkOutput("rst_mem_din", mem_din, 32'h0);
      @(negedge clk);
      #2;
    end
    s0if.valid = 1'b0; s0if.we = 1'b0; s0if.addr = '0; s0if.wdata = '0;
    s1if.valid = 1'b0; s1if.we = 1'b0; s1if.addr = '0; s1if.wdata = '0;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle either the due response is present on its port, or both ports are silent.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0 && expq[0].due <= cycle) begin
        e = expq.pop_front();
        checkOutput("resp_latency", cycle, e.due);
        checkOutput("s0_rvalid", {31'b0, s0if.rvalid}, {31'b0, e.port == 0});
        checkOutput("s1_rvalid", {31'b0, s1if.rvalid}, {31'b0, e.port == 1});
        checkOutput("owner_rdata", (e.port == 0) ? s0if.rdata : s1if.rdata, e.data);
        checkOutput("other_rdata", (e.port == 0) ? s1if.rdata : s0if.rdata, 32'h0);
      end else begin
        checkOutput("s0_rvalid_idle", {31'b0, s0if.rvalid}, 32'h0);
        checkOutput("s1_rvalid_idle", {31'b0, s1if.rvalid}, 32'h0);
        checkOutput("s0_rdata_idle", s0if.rdata, 32'h0);
        checkOutput("s1_rdata_idle", s1if.rdata, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d/%0d", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int                    w;
    logic [3:0]            pat;
    logic [3:0]            expPat;
    logic                  pv  [2];
    logic                  pwe [2];
    logic [ADDR_WIDTH-1:0] pa  [2];
    logic [WIDTH-1:0]      pd  [2];

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    s0if.valid = 1'b0; s0if.we = 1'b0; s0if.addr = '0; s0if.wdata = '0;
    s1if.valid = 1'b0; s1if.we = 1'b0; s1if.addr = '0; s1if.wdata = '0;

    doReset();

    // Contention from reset: s0 reads addr 7 while s1 writes it.
    applyStimulus(1, 0, 7, 0, 1, 1, 7, 32'hA5, w);
    checkOutput("contend_s0_first", {31'b0, s0if.ready}, 32'h1);
    applyStimulus(0, 0, 0, 0, 1, 1, 7, 32'hA5, w);
    checkOutput("contend_s1_next", {31'b0, s1if.ready}, 32'h1);
    applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, w);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, w);

    // Write then read-back on s0; the read follows the write directly.
    applyStimulus(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, w);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, w);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, w);

    // Both requesters streaming reads from reset.
    doReset();
    ram[1] = 32'h11; shadow[1] = 32'h11;
    ram[2] = 32'h22; shadow[2] = 32'h22;
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 1, 0, 1, 0, 2, 0, w);
      pat = {pat[2:0], s0if.ready};
    end
`ifdef BRAM_ARB_FIXED_PRIO_EN
    expPat = 4'b1111;
`else
    expPat = 4'b1010;
`endif
    checkOutput("grant_pattern", {28'b0, pat}, {28'b0, expPat});
    applyStimulus(0, 0, 0, 0, 1, 0, 2, 0, w);
    checkOutput("s1_after_s0_drop", {31'b0, s1if.ready}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, w);

    // Reset arriving while a read response is due.
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expq.delete();
    lastServed = 1;
    #1;
    checkOutput("midrst_s0_rvalid", {31'b0, s0if.rvalid}, 32'h0);
    checkOutput("midrst_s0_rdata", s0if.rdata, 32'h0);
    @(negedge clk);
    #2;
    s0if.valid = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1, 0, 5, 0, 1, 0, 2, 0, w);
    checkOutput("post_rst_s0_wins", {31'b0, s0if.ready}, 32'h1);

    // Randomized traffic; each requester holds its request until granted.
    pv[0] = 0; pv[1] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 3) != 0) begin
          pv[p]  = 1'b1;
          pwe[p] = 1'($urandom);
          pa[p]  = ($urandom_range(0, 9) == 0) ? ADDR_WIDTH'($urandom_range(1590, 2047))
                                               : ADDR_WIDTH'($urandom_range(0, 15));
          pd[p]  = $urandom;
        end
      end
      applyStimulus(pv[0], pwe[0], pa[0], pd[0], pv[1], pwe[1], pa[1], pd[1], w);
      if (w >= 0) pv[w] = 1'b0;
    end

    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, w);
    checkOutput("queue_drained", expq.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
